// File: rtl/tmr_fault_monitor.sv
// Triple-modular-redundancy monitor: votes three replica values, tracks
// per-replica mismatch history and raises a sticky interrupt on permanent
// failures or on samples without any majority.
module tmr_fault_monitor #(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned CNT_WIDTH   = 8,
  parameter int unsigned PERM_THRESH = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sample,
  input  logic [WIDTH-1:0]     q_1,
  input  logic [WIDTH-1:0]     q_2,
  input  logic [WIDTH-1:0]     q_3,
  input  logic                 ack,
  input  logic                 clear_perm,
  output logic [WIDTH-1:0]     voted_q,
  output logic [2:0]           fault_vec,
  output logic [CNT_WIDTH-1:0] err_cnt_1,
  output logic [CNT_WIDTH-1:0] err_cnt_2,
  output logic [CNT_WIDTH-1:0] err_cnt_3,
  output logic [2:0]           perm_fail,
  output logic                 no_majority,
  output logic                 irq
);

  typedef enum logic [1:0] {
    OK,
    SUSPECT,
    FAILED
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [3:0]           THRESH  = 4'(PERM_THRESH);

  state_t               state     [3];
  state_t               state_nxt [3];
  logic [3:0]           run       [3];
  logic [3:0]           run_nxt   [3];
  logic [CNT_WIDTH-1:0] cnt       [3];

  logic [WIDTH-1:0]     vote;
  logic [2:0]           mism;
  logic                 all_diff;
  logic [2:0]           enter_fail;
  logic                 set_evt;

  // Majority vote with bitwise fallback when no two replicas agree
  always_comb begin
    vote = (q_1 & q_2) | (q_1 & q_3) | (q_2 & q_3);
    if ((q_1 == q_2) || (q_1 == q_3)) begin
      vote = q_1;
    end else if (q_2 == q_3) begin
      vote = q_2;
    end
  end

  // Per-replica mismatch against the vote, and the no-majority condition
  always_comb begin
    mism[0]  = (q_1 != vote);
    mism[1]  = (q_2 != vote);
    mism[2]  = (q_3 != vote);
    all_diff = (q_1 != q_2) && (q_1 != q_3) && (q_2 != q_3);
  end

  // Replica health state and consecutive-mismatch run length
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < 3; i++) begin
        state[i] <= OK;
        run[i]   <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < 3; i++) begin
        state[i] <= state_nxt[i];
        run[i]   <= run_nxt[i];
      end
    end
  end

  // Next-state: clear_perm releases FAILED on any cycle; evaluation only on
  // sample cycles that have a majority
  always_comb begin
    for (int unsigned i = 0; i < 3; i++) begin
      state_nxt[i]  = state[i];
      run_nxt[i]    = run[i];
      enter_fail[i] = 1'b0;
      case (state[i])
        FAILED: begin
          if (clear_perm) begin
            state_nxt[i] = OK;
            run_nxt[i]   = '0;
          end
        end
        OK: begin
          if (sample && !all_diff && mism[i]) begin
            state_nxt[i] = SUSPECT;
            run_nxt[i]   = 4'd1;
          end
        end
        SUSPECT: begin
          if (sample && !all_diff) begin
            if (mism[i]) begin
              run_nxt[i] = run[i] + 4'd1;
              if ((run[i] + 4'd1) == THRESH) begin
                state_nxt[i]  = FAILED;
                enter_fail[i] = 1'b1;
              end
            end else begin
              state_nxt[i] = OK;
              run_nxt[i]   = '0;
            end
          end
        end
        default: begin
          state_nxt[i] = OK;
          run_nxt[i]   = '0;
        end
      endcase
    end
  end

  // Permanent-failure indication decoded from replica state
  always_comb begin
    for (int unsigned i = 0; i < 3; i++) begin
      perm_fail[i] = (state[i] == FAILED);
    end
  end

  // Registered vote result and mismatch vector, updated on sample cycles
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      voted_q   <= '0;
      fault_vec <= '0;
    end else if (sample) begin
      voted_q   <= vote;
      fault_vec <= mism;
    end
  end

  // Saturating mismatch counters, independent of replica state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < 3; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < 3; i++) begin
        if (sample && mism[i] && (cnt[i] != CNT_MAX)) begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  assign err_cnt_1 = cnt[0];
  assign err_cnt_2 = cnt[1];
  assign err_cnt_3 = cnt[2];

  assign set_evt = (|enter_fail) || (sample && all_diff);

  // Sticky flags; a coincident set event outranks ack
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      no_majority <= 1'b0;
      irq         <= 1'b0;
    end else begin
      if (sample && all_diff) begin
        no_majority <= 1'b1;
      end else if (ack) begin
        no_majority <= 1'b0;
      end
      if (set_evt) begin
        irq <= 1'b1;
      end else if (ack) begin
        irq <= 1'b0;
      end
    end
  end

endmodule

// File: doc/tmr_fault_monitor.md
TMR_FAULT_MONITOR -- requirements
Module: tmr_fault_monitor

Interface
REQ-001 Parameter WIDTH, default 4, width of each replica value.
REQ-002 Parameter CNT_WIDTH, default 8, width of each per-replica error counter.
REQ-003 Parameter PERM_THRESH, default 3, consecutive mismatching samples that declare a replica permanently failed (range 2..15).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous assert, active-low (0 = reset).
REQ-006 sample  input  1  when 1, q_1/q_2/q_3 are evaluated this cycle.
REQ-007 q_1, q_2, q_3  input  WIDTH each  replica values from the three counters.
REQ-008 ack  input  1  one-cycle pulse; clears irq and the event flags.
REQ-009 clear_perm  input  1  one-cycle pulse; returns all FAILED replicas to OK.
REQ-010 voted_q  output  WIDTH  registered majority value.
REQ-011 fault_vec  output  3  registered per-replica mismatch of the last sample (bit0 = q_1).
REQ-012 err_cnt_1, err_cnt_2, err_cnt_3  output  CNT_WIDTH each  saturating mismatch counters.
REQ-013 perm_fail  output  3  per-replica FAILED state indicator.
REQ-014 no_majority  output  1  sticky: a sample had all three replicas mutually different.
REQ-015 irq  output  1  level interrupt, held until ack.

Function
REQ-016 Vote = q_1 if q_1==q_2 or q_1==q_3; else q_2 if q_2==q_3; else bitwise majority (q_1&q_2)|(q_1&q_3)|(q_2&q_3).
REQ-017 On a sample cycle, voted_q and fault_vec update on the next edge (latency 1); fault_vec[i] = (q_i != vote).
REQ-018 With sample=0, voted_q, fault_vec, counters and FSMs hold.
REQ-019 Each replica has an FSM {OK, SUSPECT, FAILED}, sample cycles only.
REQ-020 OK: mismatch -> SUSPECT, run length = 1; match -> stay OK.
REQ-021 SUSPECT: match -> OK, run length cleared; mismatch -> run length +1; when run length reaches PERM_THRESH -> FAILED.
REQ-022 FAILED: sticky regardless of further samples; left only by clear_perm (-> OK, run length 0) or reset.
REQ-023 perm_fail[i] = 1 exactly while replica i is FAILED.
REQ-024 err_cnt_i increments by 1 on every mismatching sample, including while FAILED; saturates at 2^CNT_WIDTH-1; no wrap.
REQ-025 no_majority sets on any sample where all three replicas differ; on that sample no replica changes FSM state, but counters still increment for mismatches.
REQ-026 irq sets on the edge where any replica enters FAILED or no_majority sets.
REQ-027 ack clears irq and no_majority; a new set-event in the same cycle as ack wins (irq stays 1).
REQ-028 clear_perm coincident with a mismatching sample: clear takes priority, replica goes to OK with run length 0, counter still increments.
REQ-029 Counters cleared only by reset; ack and clear_perm do not touch them.

Reset
REQ-030 While rst=0: voted_q=0, fault_vec=0, all err_cnt=0, all FSMs OK with run length 0, perm_fail=0, no_majority=0, irq=0.
REQ-031 Reset asserted mid-run clears all state immediately, without waiting for a clock edge; release is synchronous to clk.

Verification
REQ-032 q_1=q_2=q_3=5, sample=1 for 10 cycles -> voted_q=5, fault_vec=0, counters 0, irq=0.
REQ-033 q_2=7 while q_1=q_3=5 for 3 samples (PERM_THRESH=3) -> fault_vec=3'b010 each, err_cnt_2=3, perm_fail=3'b010 and irq=1 after the 3rd sample edge; ack -> irq=0, perm_fail holds.
REQ-034 q_3 mismatch for 2 samples, then match -> replica 3 returns to OK, err_cnt_3=2, perm_fail=0, irq=0.
REQ-035 q_1=1, q_2=2, q_3=4 one sample -> voted_q=0, fault_vec=3'b111, no_majority=1, irq=1, all FSMs unchanged; ack in the same cycle as a second such sample -> irq stays 1.
REQ-036 Force q_1 mismatch for 300 samples with CNT_WIDTH=8 -> err_cnt_1 saturates at 255; clear_perm -> perm_fail[0]=0, err_cnt_1 stays 255; rst=0 mid-sequence -> all outputs 0 immediately.
